// File: rtl/div_seq_ctrl.sv
// Sequencer for the shared signed/unsigned AXI-stream divider IPs: feeds one
// request's operands, captures the one-cycle result pulse and holds it for EX.
module div_seq_ctrl #(
   parameter int unsigned DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic [1:0]      req_op,
   input  logic [DW-1:0]   req_src1,
   input  logic [DW-1:0]   req_src2,
   output logic            req_ready,
   input  logic            flush,
   output logic            out_valid,
   output logic [DW-1:0]   out_result,
   input  logic            out_ready,
   output logic [DW-1:0]   dividend_data,
   output logic [DW-1:0]   divisor_data,
   output logic            sdiv_dividend_tvalid,
   output logic            sdiv_divisor_tvalid,
   input  logic            sdiv_dividend_tready,
   input  logic            sdiv_divisor_tready,
   input  logic            sdiv_dout_tvalid,
   input  logic [2*DW-1:0] sdiv_dout_tdata,
   output logic            udiv_dividend_tvalid,
   output logic            udiv_divisor_tvalid,
   input  logic            udiv_dividend_tready,
   input  logic            udiv_divisor_tready,
   input  logic            udiv_dout_tvalid,
   input  logic [2*DW-1:0] udiv_dout_tdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [DW-1:0]   dividend_q, dividend_d;
   logic [DW-1:0]   divisor_q, divisor_d;
   logic [DW-1:0]   result_q, result_d;
   logic            dvd_done_q, dvd_done_d;
   logic            dvs_done_q, dvs_done_d;
   logic            killed_q, killed_d;

   logic            sel_u;
   logic            dvd_tvalid, dvs_tvalid;
   logic            dvd_tready, dvs_tready;
   logic            dvd_hs, dvs_hs;
   logic            dout_tvalid;
   logic [2*DW-1:0] dout_tdata;

   // op[1] steers every handshake to exactly one IP; the other IP is invisible.
   always_comb begin
      sel_u       = op_q[1];
      dvd_tvalid  = (state_q == S_ISSUE) && !dvd_done_q;
      dvs_tvalid  = (state_q == S_ISSUE) && !dvs_done_q;
      dvd_tready  = sel_u ? udiv_dividend_tready : sdiv_dividend_tready;
      dvs_tready  = sel_u ? udiv_divisor_tready  : sdiv_divisor_tready;
      dvd_hs      = dvd_tvalid && dvd_tready;
      dvs_hs      = dvs_tvalid && dvs_tready;
      dout_tvalid = sel_u ? udiv_dout_tvalid : sdiv_dout_tvalid;
      dout_tdata  = sel_u ? udiv_dout_tdata  : sdiv_dout_tdata;
   end

   always_comb begin
      sdiv_dividend_tvalid = dvd_tvalid && !sel_u;
      sdiv_divisor_tvalid  = dvs_tvalid && !sel_u;
      udiv_dividend_tvalid = dvd_tvalid && sel_u;
      udiv_divisor_tvalid  = dvs_tvalid && sel_u;
      req_ready            = (state_q == S_IDLE);
      out_valid            = (state_q == S_DONE);
      out_result           = result_q;
      dividend_data        = dividend_q;
      divisor_data         = divisor_q;
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      result_d   = result_q;
      dvd_done_d = dvd_done_q;
      dvs_done_d = dvs_done_q;
      killed_d   = killed_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid && !flush) begin
               state_d    = S_ISSUE;
               op_d       = req_op;
               dividend_d = req_src1;
               divisor_d  = req_src2;
               dvd_done_d = 1'b0;
               dvs_done_d = 1'b0;
            end
         end
         S_ISSUE: begin
            dvd_done_d = dvd_done_q || dvd_hs;
            dvs_done_d = dvs_done_q || dvs_hs;
            // Abort cleanly only if the IP has taken nothing; otherwise finish
            // feeding it and drain the result it is now committed to produce.
            if (flush && !dvd_done_d && !dvs_done_d) begin
               state_d = S_IDLE;
            end else begin
               if (flush) killed_d = 1'b1;
               if (dvd_done_d && dvs_done_d) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (dout_tvalid) begin
               if (killed_q || flush) begin
                  state_d = S_IDLE;
               end else begin
                  result_d = op_q[0] ? dout_tdata[DW-1:0] : dout_tdata[2*DW-1:DW];
                  state_d  = S_DONE;
               end
            end else if (flush) begin
               killed_d = 1'b1;
            end
         end
         S_DONE: begin
            if (flush || out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_IDLE) killed_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         result_q   <= '0;
         dvd_done_q <= 1'b0;
         dvs_done_q <= 1'b0;
         killed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         result_q   <= result_d;
         dvd_done_q <= dvd_done_d;
         dvs_done_q <= dvs_done_d;
         killed_q   <= killed_d;
      end
   end

endmodule
